// File: rtl/secuenciador_operandos.sv
// Operand sequencer: loads three operands for the OPERACIONES unit, waits LATENCIA
// cycles, then captures the result and hands it downstream with a valid/ready handshake.
module secuenciador_operandos #(
  parameter int unsigned LATENCIA = 1  // legal range 1..7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] dato_in,
  input  logic       dato_valido,
  output logic       dato_listo,
  input  logic       cancelar,
  output logic [5:0] operando1,
  output logic [5:0] operando2,
  output logic [5:0] operando3,
  input  logic [5:0] resultado_operacion,
  input  logic       salidawar1,
  input  logic [2:0] salidawar2,
  output logic [5:0] resultado_out,
  output logic       war1_out,
  output logic [2:0] war2_out,
  output logic       resultado_valido,
  input  logic       resultado_listo,
  output logic       ocupado,
  output logic [7:0] contador_ops
);

  typedef enum logic [2:0] {
    CARGA1  = 3'd0,
    CARGA2  = 3'd1,
    CARGA3  = 3'd2,
    ESPERA  = 3'd3,
    ENTREGA = 3'd4
  } estado_e;

  localparam logic [2:0] LAT = 3'(LATENCIA);

  estado_e     estado_reg, estado_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [2:0]  carga_en;
  logic        captura;
  logic        handshake;
  logic [17:0] operandos;
  logic [5:0]  resultado_reg;
  logic        war1_reg;
  logic [2:0]  war2_reg;
  logic        valido_reg;
  logic [7:0]  contador_reg;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_reg <= CARGA1;
    end else begin
      estado_reg <= estado_next;
    end
  end

  // Next-state logic; cancelar outranks a simultaneous transfer or capture
  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      CARGA1: begin
        if (carga_en[0]) estado_next = CARGA2;
      end
      CARGA2: begin
        if (cancelar)         estado_next = CARGA1;
        else if (carga_en[1]) estado_next = CARGA3;
      end
      CARGA3: begin
        if (cancelar)         estado_next = CARGA1;
        else if (carga_en[2]) estado_next = ESPERA;
      end
      ESPERA: begin
        if (cancelar)     estado_next = CARGA1;
        else if (captura) estado_next = ENTREGA;
      end
      ENTREGA: begin
        if (handshake) estado_next = CARGA1;
      end
      default: estado_next = CARGA1;
    endcase
  end

  // Output/strobe decode; illegal encodings look busy and refuse operands
  always_comb begin
    dato_listo = 1'b0;
    ocupado    = 1'b1;
    carga_en   = 3'b000;
    captura    = 1'b0;
    handshake  = 1'b0;
    case (estado_reg)
      CARGA1: begin
        dato_listo  = 1'b1;
        ocupado     = 1'b0;
        carga_en[0] = dato_valido;
      end
      CARGA2: begin
        dato_listo  = 1'b1;
        carga_en[1] = dato_valido & ~cancelar;
      end
      CARGA3: begin
        dato_listo  = 1'b1;
        carga_en[2] = dato_valido & ~cancelar;
      end
      ESPERA: begin
        captura = ~cancelar & (cnt_reg == 3'd1);
      end
      ENTREGA: begin
        handshake = resultado_listo;
      end
      default: begin
        dato_listo = 1'b0;
      end
    endcase
  end

  // Wait counter: loaded on the operando3 transfer, so capture lands LATENCIA edges later
  always_comb begin
    cnt_next = cnt_reg;
    if (carga_en[2]) begin
      cnt_next = LAT;
    end else if (estado_reg == ESPERA && cnt_reg != 3'd0) begin
      cnt_next = cnt_reg - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= 3'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_operando
      logic [5:0] operando_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          operando_reg <= 6'd0;
        end else if (carga_en[gi]) begin
          operando_reg <= dato_in;
        end
      end
      assign operandos[gi*6 +: 6] = operando_reg;
    end
  endgenerate

  assign operando1 = operandos[5:0];
  assign operando2 = operandos[11:6];
  assign operando3 = operandos[17:12];

  // Captured result stays frozen through ENTREGA until the handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resultado_reg <= 6'd0;
      war1_reg      <= 1'b0;
      war2_reg      <= 3'd0;
    end else if (captura) begin
      resultado_reg <= resultado_operacion;
      war1_reg      <= salidawar1;
      war2_reg      <= salidawar2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valido_reg   <= 1'b0;
      contador_reg <= 8'd0;
    end else begin
      if (captura) begin
        valido_reg <= 1'b1;
      end else if (handshake) begin
        valido_reg <= 1'b0;
      end
      if (handshake) begin
        contador_reg <= contador_reg + 8'd1;
      end
    end
  end

  assign resultado_out    = resultado_reg;
  assign war1_out         = war1_reg;
  assign war2_out         = war2_reg;
  assign resultado_valido = valido_reg;
  assign contador_ops     = contador_reg;

endmodule
